// File: rtl/nibble_serial_add_seq.sv
// Nibble-serial adder: streams W-bit operands through an external 4-bit
// CLA stage one nibble per cycle, with valid/ready handshakes on both sides.
module nibble_serial_add_seq #(
  parameter int N_NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*N_NIBBLES-1:0] a,
  input  logic [4*N_NIBBLES-1:0] b,
  input  logic                   cin,
  output logic [3:0]             cla_a,
  output logic [3:0]             cla_b,
  output logic                   cla_cin,
  input  logic [3:0]             cla_sum,
  input  logic                   cla_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*N_NIBBLES-1:0] sum,
  output logic                   cout,
  output logic                   ovf,
  output logic                   busy
);

  localparam int W  = 4 * N_NIBBLES;
  localparam int IW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            cin_q, cin_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [IW+1:0]   sh;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    nib_mask;
  logic            last;

  // Bit offset of the current nibble inside the operand registers.
  assign sh       = {idx_q, 2'b00};
  assign a_sh     = a_q >> sh;
  assign b_sh     = b_q >> sh;
  assign nib_mask = W'(4'hF) << sh;
  assign last     = (idx_q == IW'(N_NIBBLES - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cla_a     = 4'h0;
    cla_b     = 4'h0;
    cla_cin   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cin_d   = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cla_a   = a_sh[3:0];
        cla_b   = b_sh[3:0];
        cla_cin = (idx_q == '0) ? cin_q : carry_q;
        sum_d   = (sum_q & ~nib_mask) | (W'(cla_sum) << sh);
        carry_d = cla_cout;
        if (last) begin
          cout_d  = cla_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) &
                    (cla_sum[3] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != IDLE);

endmodule
